// File: rtl/ram_io_responder_pkg.sv
// Shared bus widths, I/O window addresses and read/write encodings for the
// byte-serial RAM bus between the memory arbiter and the RAM/I/O responder.
package ram_io_responder_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int RAM_RW_WIDTH  = 8;

  localparam logic [ADDRESS_WIDTH-1:0] DEF_IO_TX_ADDR   = 32'h0003_0000;
  localparam logic [ADDRESS_WIDTH-1:0] DEF_IO_STAT_ADDR = 32'h0003_0004;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  function automatic logic [RAM_RW_WIDTH-1:0] status_byte(input logic overflow,
                                                           input logic full);
    return {6'b0, overflow, full};
  endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Arbiter-to-responder byte bus plus the TX byte stream towards the host side.
interface ram_io_responder_if;
  import ram_io_responder_pkg::*;

  logic                     rdy_in;
  logic                     ram_rw_in;
  logic [ADDRESS_WIDTH-1:0] ram_addr_in;
  logic [RAM_RW_WIDTH-1:0]  ram_wdata_in;
  logic [RAM_RW_WIDTH-1:0]  ram_rdata_out;
  logic                     io_tx_valid_out;
  logic [RAM_RW_WIDTH-1:0]  io_tx_data_out;
  logic                     io_tx_ready_in;
  logic                     io_full_out;

  modport master (
    output rdy_in, ram_rw_in, ram_addr_in, ram_wdata_in, io_tx_ready_in,
    input  ram_rdata_out, io_tx_valid_out, io_tx_data_out, io_full_out
  );

  modport slave (
    input  rdy_in, ram_rw_in, ram_addr_in, ram_wdata_in, io_tx_ready_in,
    output ram_rdata_out, io_tx_valid_out, io_tx_data_out, io_full_out
  );

endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte FIFO with wrapping pointers; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = en && pop && (count != '0);
  assign do_push = en && push && ((count != FULL_COUNT) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// Memory-side responder: byte RAM with one-cycle read latency plus an I/O
// window holding a TX byte FIFO and a status register with a sticky overflow flag.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int                       RAM_ADDR_BITS = 17,
  parameter int                       FIFO_DEPTH    = 16,
  parameter logic [ADDRESS_WIDTH-1:0] IO_TX_ADDR    = DEF_IO_TX_ADDR,
  parameter logic [ADDRESS_WIDTH-1:0] IO_STAT_ADDR  = DEF_IO_STAT_ADDR
) (
  input logic               clk_in,
  input logic               rst_in,
  ram_io_responder_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [RAM_RW_WIDTH-1:0]  mem [2**RAM_ADDR_BITS];
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [RAM_RW_WIDTH-1:0]  rdata;
  logic [CW-1:0]            count;
  logic                     is_io;
  logic                     is_write;
  logic                     is_tx;
  logic                     is_stat;
  logic                     push;
  logic                     valid;
  logic                     full;
  logic                     overflow;

  // Upper address bits above the RAM size are dropped, so RAM addresses alias.
  assign ram_addr = bus.ram_addr_in[RAM_ADDR_BITS-1:0];
  assign is_io    = (bus.ram_addr_in[17:16] == 2'b11);
  assign is_write = (bus.ram_rw_in == RW_WRITE);
  assign is_tx    = (bus.ram_addr_in == IO_TX_ADDR);
  assign is_stat  = (bus.ram_addr_in == IO_STAT_ADDR);
  assign push     = is_write && is_tx;
  assign valid    = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));

  assign bus.ram_rdata_out   = rdata;
  assign bus.io_tx_valid_out = valid;
  assign bus.io_full_out     = full;

  always_ff @(posedge clk_in) begin
    if (bus.rdy_in && is_write && !is_io) begin
      mem[ram_addr] <= bus.ram_wdata_in;
    end
  end

  // Write cycles return zero; I/O reads sample the status at the request cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rdata <= '0;
    end else if (bus.rdy_in) begin
      if (is_write) begin
        rdata <= '0;
      end else if (is_io) begin
        rdata <= is_stat ? status_byte(overflow, full) : '0;
      end else begin
        rdata <= mem[ram_addr];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow <= 1'b0;
    end else if (bus.rdy_in) begin
      if (is_write && is_stat) begin
        overflow <= 1'b0;
      end else if (push && full && !(valid && bus.io_tx_ready_in)) begin
        overflow <= 1'b1;
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .en    (bus.rdy_in),
    .push  (push),
    .pop   (bus.io_tx_ready_in),
    .din   (bus.ram_wdata_in),
    .dout  (bus.io_tx_data_out),
    .count (count)
  );

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed, table-driven bench for ram_io_responder: RAM read/write timing,
// TX FIFO ordering and overflow, aliasing, reset and rdy_in stalls.
module tb_ram_io_responder;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  ram_io_responder_if bus ();

  ram_io_responder dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  exp_rdata;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_full;
  } vec_t;

  vec_t vecs [18];

  // Drive one bus cycle, let the edge happen, then settle before sampling.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr,
                               input logic [7:0] wdata, input logic ready,
                               input logic rdy, input logic rst);
    bus.ram_rw_in      = rw;
    bus.ram_addr_in    = addr;
    bus.ram_wdata_in   = wdata;
    bus.io_tx_ready_in = ready;
    bus.rdy_in         = rdy;
    rst_in             = rst;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input logic [7:0] exp_rdata,
                            input logic exp_valid, input logic [7:0] exp_data,
                            input logic exp_full);
    checkOutput({name, ".rdata"}, bus.ram_rdata_out, exp_rdata);
    checkOutput({name, ".valid"}, {7'b0, bus.io_tx_valid_out}, {7'b0, exp_valid});
    checkOutput({name, ".full"}, {7'b0, bus.io_full_out}, {7'b0, exp_full});
    if (exp_valid) begin
      checkOutput({name, ".data"}, bus.io_tx_data_out, exp_data);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0100, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0101, 8'h22, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0102, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0103, 8'h44, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0101, 8'h00, 1'b0, 8'h22, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0102, 8'h00, 1'b0, 8'h33, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0103, 8'h00, 1'b0, 8'h44, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 32'h0003_0000, 8'h41, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
    vecs[9]  = '{1'b1, 32'h0003_0000, 8'h42, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
    vecs[10] = '{1'b0, 32'h0003_0004, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'h11, 1'b1, 8'h42, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0101, 8'h00, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 32'h0002_0005, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0005, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[16] = '{1'b1, 32'h0003_0008, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[17] = '{1'b0, 32'h0003_0008, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};

    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkState("reset", 8'h00, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].ready, 1'b1, 1'b0);
      checkState($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_valid,
                 vecs[i].exp_data, vecs[i].exp_full);
    end

    // Fill the FIFO, then one extra push that must be dropped and flag overflow.
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1, 32'h0003_0000, 8'(8'h7F + i), 1'b0, 1'b1, 1'b0);
      checkState($sformatf("fill%0d", i), 8'h00, 1'b1, 8'h80, (i >= 16));
    end
    applyStimulus(1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("stat_ovf", 8'h03, 1'b1, 8'h80, 1'b1);
    applyStimulus(1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("stat_clr", 8'h00, 1'b1, 8'h80, 1'b1);
    applyStimulus(1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("stat_after_clr", 8'h01, 1'b1, 8'h80, 1'b1);

    // Push while full with a pop in the same cycle: both happen, no overflow.
    applyStimulus(1'b1, 32'h0003_0000, 8'h99, 1'b1, 1'b1, 1'b0);
    checkState("full_push_pop", 8'h00, 1'b1, 8'h81, 1'b1);
    applyStimulus(1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("stat_no_ovf", 8'h01, 1'b1, 8'h81, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("drain%0d.data", k), bus.io_tx_data_out,
                  (k < 15) ? 8'(8'h81 + k) : 8'h99);
      checkOutput($sformatf("drain%0d.valid", k), {7'b0, bus.io_tx_valid_out}, 8'h01);
      applyStimulus(1'b0, 32'h0000_0100, 8'h00, 1'b1, 1'b1, 1'b0);
    end
    checkState("drained", 8'h11, 1'b0, 8'h00, 1'b0);

    // rdy_in low: push, RAM write and read all held off.
    applyStimulus(1'b0, 32'h0000_0103, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("pre_hold", 8'h44, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h0003_0000, 8'h55, 1'b0, 1'b0, 1'b0);
    checkState("hold_push", 8'h44, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h0000_0100, 8'hEE, 1'b0, 1'b0, 1'b0);
    checkState("hold_write", 8'h44, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 32'h0000_0101, 8'h00, 1'b1, 1'b0, 1'b0);
    checkState("hold_read", 8'h44, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h0003_0000, 8'h55, 1'b0, 1'b1, 1'b0);
    checkState("resume_push", 8'h00, 1'b1, 8'h55, 1'b0);
    applyStimulus(1'b0, 32'h0000_0101, 8'h00, 1'b1, 1'b1, 1'b0);
    checkState("resume_pop", 8'h22, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 32'h0000_0100, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("no_held_write", 8'h11, 1'b0, 8'h00, 1'b0);

    // Reset mid-stream: read result and queued TX bytes are lost, RAM kept.
    applyStimulus(1'b1, 32'h0003_0000, 8'h66, 1'b0, 1'b1, 1'b0);
    checkState("pre_rst_push", 8'h00, 1'b1, 8'h66, 1'b0);
    applyStimulus(1'b0, 32'h0000_0005, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("pre_rst_read", 8'h5A, 1'b1, 8'h66, 1'b0);
    applyStimulus(1'b0, 32'h0000_0101, 8'h00, 1'b0, 1'b1, 1'b1);
    checkState("mid_rst", 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 32'h0000_0005, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("post_rst_ram", 8'h5A, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0);
    checkState("post_rst_stat", 8'h00, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
